da_tap_slicer: RTL and testbench

Upstream feeder for the `da` distributed-arithmetic FIR core. Accepts one parallel input sample per output, holds a 64-tap delay line and, for each accepted sample, streams `SAMPLE_W` bit-slices onto the eight 8-bit ROM address buses (`A7`..`A0`) of `da`, LSB slice first. It then waits for `da` to report `done` before accepting the next sample. It replaces the free-running address stimulus used in block-level DA simulation with a real sample-driven front end.

---
 rtl/da_pkg.sv | 21 ++
 rtl/da_tap_line.sv | 58 +++++
 rtl/da_tap_slicer.sv | 174 +++++++++++++++++
 tb/tb_da_tap_slicer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/da_pkg.sv
// -----------------------------------------------------------------------------
// da_pkg
// Shared definitions for the distributed-arithmetic FIR front end.
//   DA_NGROUP      : number of ROM groups / address buses driven into `da`
//   DA_GROUP_W     : taps per group (ROM address width)
//   DA_NTAPS       : total delay-line length
//   slicer_state_t : sequencing states of da_tap_slicer
// -----------------------------------------------------------------------------
package da_pkg;

  localparam int DA_NGROUP  = 8;
  localparam int DA_GROUP_W = 8;
  localparam int DA_NTAPS   = DA_NGROUP * DA_GROUP_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLICE = 2'd1,
    WAIT  = 2'd2
  } slicer_state_t;

endpackage

// File: rtl/da_tap_line.sv
// -----------------------------------------------------------------------------
// da_tap_line
// NTAPS x SAMPLE_W shift register (tap 0 newest) with a bit-slice mux.
//   clk, reset : clock, asynchronous active-high reset (clears every tap)
//   shift_en   : shift the line up by one and load x_in into tap 0
//   clr        : zero every tap at the next edge (has priority over shift_en)
//   x_in       : sample loaded on shift
//   bit_sel    : bit index b to slice out
//   slice      : slice[t] = bit b of tap t, taken from the line's NEXT contents
//
// The slice is taken from the next-state view so the owner can register
// slice 0 of a freshly accepted sample on the very edge that shifts it in.
// -----------------------------------------------------------------------------
module da_tap_line
  import da_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int NTAPS    = DA_NTAPS,
  parameter int BIT_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                shift_en,
  input  logic                clr,
  input  logic [SAMPLE_W-1:0] x_in,
  input  logic [BIT_W-1:0]    bit_sel,
  output logic [NTAPS-1:0]    slice
);

  logic [SAMPLE_W-1:0] tap_q [NTAPS];
  logic [SAMPLE_W-1:0] tap_d [NTAPS];

  generate
    for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap
      if (gi == 0) begin : g_head
        always_comb begin
          tap_d[gi] = tap_q[gi];
          if (clr)           tap_d[gi] = '0;
          else if (shift_en) tap_d[gi] = x_in;
        end
      end else begin : g_body
        always_comb begin
          tap_d[gi] = tap_q[gi];
          if (clr)           tap_d[gi] = '0;
          else if (shift_en) tap_d[gi] = tap_q[gi-1];
        end
      end

      assign slice[gi] = tap_d[gi][bit_sel];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) tap_q[gi] <= '0;
        else       tap_q[gi] <= tap_d[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/da_tap_slicer.sv
// -----------------------------------------------------------------------------
// da_tap_slicer
// Sample-driven front end for the `da` DA FIR core. Accepts one sample, shifts
// it into a 64-tap delay line, then streams SAMPLE_W bit-slices (LSB first)
// onto eight 8-bit ROM address buses and waits for `da_done`.
//
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   x_in/x_valid : sample input; accepted when x_ready is high
//   x_ready      : high only in IDLE (and not while flushing)
//   A7..A0       : registered bit-slice address per ROM group, A_k[j]=tap[8k+j][b]
//   slice_valid  : A* carry a slice this cycle
//   start_out    : first slice of an output (drives da.start)
//   last_slice   : sign slice (da subtracts this term)
//   da_done      : da.done, only honoured in WAIT
//   flush        : synchronous delay-line clear in IDLE (DA_SLICER_FLUSH_EN only)
//
// Build option: define DA_SLICER_FLUSH_EN to add the `flush` port.
// -----------------------------------------------------------------------------
module da_tap_slicer
  import da_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int NGROUP   = DA_NGROUP,
  parameter int GROUP_W  = DA_GROUP_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] x_in,
  input  logic                x_valid,
  output logic                x_ready,
  output logic [GROUP_W-1:0]  A7,
  output logic [GROUP_W-1:0]  A6,
  output logic [GROUP_W-1:0]  A5,
  output logic [GROUP_W-1:0]  A4,
  output logic [GROUP_W-1:0]  A3,
  output logic [GROUP_W-1:0]  A2,
  output logic [GROUP_W-1:0]  A1,
  output logic [GROUP_W-1:0]  A0,
  output logic                slice_valid,
  output logic                start_out,
  output logic                last_slice,
`ifdef DA_SLICER_FLUSH_EN
  input  logic                da_done,
  input  logic                flush
`else
  input  logic                da_done
`endif
);

  localparam int NTAPS = NGROUP * GROUP_W;
  localparam int BIT_W = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
  localparam logic [BIT_W-1:0] LAST_B = BIT_W'(SAMPLE_W - 1);

  logic flush_i;
`ifdef DA_SLICER_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  slicer_state_t      state_q, state_d;
  logic [BIT_W-1:0]   b_q, b_d;
  logic [GROUP_W-1:0] a_q [NGROUP];
  logic [GROUP_W-1:0] a_d [NGROUP];
  logic               slice_valid_q, slice_valid_d;
  logic               start_q, start_d;
  logic               last_q, last_d;

  logic               accept;
  logic               shift_en;
  logic               clr;
  logic [BIT_W-1:0]   bit_sel;
  logic [NTAPS-1:0]   slice;

  // Flush wins over a simultaneous sample.
  assign accept  = (state_q == IDLE) && x_valid && !flush_i;
  assign x_ready = (state_q == IDLE) && !flush_i;

  // Delay-line controls kept apart from the output logic so the slice path
  // is a clean feed-forward: state/counter -> bit_sel -> slice -> a_d.
  // b_q is the slice currently on the buses; bit_sel is the one to register
  // next, held at the last index once the sign slice has gone out.
  always_comb begin
    shift_en = accept;
    clr      = (state_q == IDLE) && flush_i;
    if (state_q == IDLE)  bit_sel = '0;
    else if (b_q == LAST_B) bit_sel = b_q;
    else                  bit_sel = b_q + BIT_W'(1);
  end

  da_tap_line #(
    .SAMPLE_W (SAMPLE_W),
    .NTAPS    (NTAPS),
    .BIT_W    (BIT_W)
  ) u_tap_line (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .clr      (clr),
    .x_in     (x_in),
    .bit_sel  (bit_sel),
    .slice    (slice)
  );

  always_comb begin
    state_d       = state_q;
    b_d           = b_q;
    slice_valid_d = 1'b0;
    start_d       = 1'b0;
    last_d        = 1'b0;
    for (int k = 0; k < NGROUP; k++) a_d[k] = a_q[k];

    case (state_q)
      IDLE: begin
        if (accept) begin
          // Slice 0 of the new sample goes out on the accepting edge.
          state_d       = SLICE;
          b_d           = '0;
          slice_valid_d = 1'b1;
          start_d       = 1'b1;
          last_d        = (bit_sel == LAST_B);
          for (int k = 0; k < NGROUP; k++) a_d[k] = slice[k*GROUP_W +: GROUP_W];
        end
      end
      SLICE: begin
        if (b_q == LAST_B) begin
          // Sign slice has been shown; buses hold it while we wait.
          state_d = WAIT;
        end else begin
          b_d           = bit_sel;
          slice_valid_d = 1'b1;
          last_d        = (bit_sel == LAST_B);
          for (int k = 0; k < NGROUP; k++) a_d[k] = slice[k*GROUP_W +: GROUP_W];
        end
      end
      WAIT: begin
        if (da_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      b_q           <= '0;
      slice_valid_q <= 1'b0;
      start_q       <= 1'b0;
      last_q        <= 1'b0;
      for (int k = 0; k < NGROUP; k++) a_q[k] <= '0;
    end else begin
      state_q       <= state_d;
      b_q           <= b_d;
      slice_valid_q <= slice_valid_d;
      start_q       <= start_d;
      last_q        <= last_d;
      for (int k = 0; k < NGROUP; k++) a_q[k] <= a_d[k];
    end
  end

  assign slice_valid = slice_valid_q;
  assign start_out   = start_q;
  assign last_slice  = last_q;
  assign A0 = a_q[0];
  assign A1 = a_q[1];
  assign A2 = a_q[2];
  assign A3 = a_q[3];
  assign A4 = a_q[4];
  assign A5 = a_q[5];
  assign A6 = a_q[6];
  assign A7 = a_q[7];

endmodule

// File: tb/tb_da_tap_slicer.sv
// -----------------------------------------------------------------------------
// tb_da_tap_slicer
// Self-checking bench for da_tap_slicer. A behavioural model (delay line as a
// plain array, progress tracked as "edges since accept") predicts every output
// each cycle; directed transactions add hand-computed literal expectations.
// Build option: DA_SLICER_FLUSH_EN adds the flush test.
// -----------------------------------------------------------------------------
module tb_da_tap_slicer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] x_in = 16'h0;
  logic        x_valid = 1'b0;
  logic        da_done = 1'b0;
  logic        x_ready, slice_valid, start_out, last_slice;
  logic [7:0]  A7, A6, A5, A4, A3, A2, A1, A0;
  logic        flush_s;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

`ifdef DA_SLICER_FLUSH_EN
  logic flush = 1'b0;
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  da_tap_slicer dut (
    .clk(clk), .reset(reset), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .A7(A7), .A6(A6), .A5(A5), .A4(A4), .A3(A3), .A2(A2), .A1(A1), .A0(A0),
    .slice_valid(slice_valid), .start_out(start_out), .last_slice(last_slice),
`ifdef DA_SLICER_FLUSH_EN
    .da_done(da_done), .flush(flush)
`else
    .da_done(da_done)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] bus [8];
  assign bus[0] = A0; assign bus[1] = A1; assign bus[2] = A2; assign bus[3] = A3;
  assign bus[4] = A4; assign bus[5] = A5; assign bus[6] = A6; assign bus[7] = A7;

  // ---------------- behavioural model ----------------
  logic [15:0] m_line [64];
  bit          m_busy;
  int          m_cnt;       // edges since accept; 16 means waiting for done
  logic [7:0]  m_a [8];

  function automatic logic [7:0] m_bus(input int k, input int b);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = m_line[8*k+j][b];
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < 64; t++) m_line[t] = 16'h0;
      for (int k = 0; k < 8; k++) m_a[k] = 8'h0;
      m_busy = 1'b0;
      m_cnt  = 0;
    end else if (!m_busy) begin
      if (flush_s) begin
        for (int t = 0; t < 64; t++) m_line[t] = 16'h0;
      end else if (x_valid) begin
        for (int t = 63; t > 0; t--) m_line[t] = m_line[t-1];
        m_line[0] = x_in;
        m_busy = 1'b1;
        m_cnt  = 0;
        for (int k = 0; k < 8; k++) m_a[k] = m_bus(k, 0);
      end
    end else begin
      if (m_cnt < 15) begin
        m_cnt = m_cnt + 1;
        for (int k = 0; k < 8; k++) m_a[k] = m_bus(k, m_cnt);
      end else if (m_cnt == 15) begin
        m_cnt = 16;
      end else if (da_done) begin
        m_busy = 1'b0;
      end
    end
  end

  // Per-cycle compare, sampled 1 time unit before the falling edge.
  initial begin
    logic [67:0] exp_v, act_v;
    forever begin
      @(posedge clk);
      #4;
      if (cmp_en) begin
        exp_v = {!m_busy && !flush_s, m_busy && m_cnt <= 15, m_busy && m_cnt == 0,
                 m_busy && m_cnt == 15, m_a[7], m_a[6], m_a[5], m_a[4],
                 m_a[3], m_a[2], m_a[1], m_a[0]};
        act_v = {x_ready, slice_valid, start_out, last_slice,
                 A7, A6, A5, A4, A3, A2, A1, A0};
        n_tests++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL cycle_model t=%0t: got {rdy,sv,st,last,A7..A0}=%h expected %h",
                   $time, act_v, exp_v);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  logic [7:0] cap_a [16][8];
  logic       cap_st [16];
  logic       cap_ls [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && x_ready !== 1'b1; i++) @(negedge clk);
    chk("x_ready_timeout", {31'd0, x_ready}, 32'd1);
  endtask

  task automatic capture(input int i);
    for (int k = 0; k < 8; k++) cap_a[i][k] = bus[k];
    cap_st[i] = start_out;
    cap_ls[i] = last_slice;
  endtask

  task automatic push(input logic [15:0] s, input int dly);
    wait_ready();
    x_in = s; x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0; x_in = 16'hDEAD;
    for (int i = 0; i < 16; i++) begin
      capture(i);
      @(negedge clk);
    end
    repeat (dly) @(negedge clk);
    da_done = 1'b1;
    @(negedge clk);
    da_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Checks captured slices against A0 pattern a0_of(i) = (mask>>i)&1 ? a0v : 0,
  // A1 = a1v on every slice, others zero, start only on 0, last only on 15.
  task automatic chk_slices(input string nm, input logic [15:0] a0_mask,
                            input logic [7:0] a0v, input logic [7:0] a1v);
    logic [7:0] others;
    for (int i = 0; i < 16; i++) begin
      others = cap_a[i][2] | cap_a[i][3] | cap_a[i][4] | cap_a[i][5] | cap_a[i][6] | cap_a[i][7];
      chk($sformatf("%s_s%0d", nm, i),
          {6'd0, cap_st[i], cap_ls[i], others, cap_a[i][1], cap_a[i][0]},
          {6'd0, i == 0, i == 15, 8'h00, a1v, a0_mask[i] ? a0v : 8'h00});
    end
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] rv [6] = '{16'h1234, 16'hA5A5, 16'h0F0F, 16'h8001, 16'h7FFE, 16'hC3C3};
  int          rd [6] = '{0, 1, 3, 0, 2, 7};

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset_during", {x_ready, slice_valid, start_out, last_slice,
                         A7 | A6 | A5 | A4 | A3 | A2 | A1 | A0}, {4'b1000, 8'h00});
    reset = 1'b0;
    @(negedge clk);
    chk("reset_after", {x_ready, slice_valid, start_out, last_slice,
                        A7 | A6 | A5 | A4 | A3 | A2 | A1 | A0}, {4'b1000, 8'h00});

    // 0x0001 after reset: A0 = 01 only on slice 0
    push(16'h0001, 0);
    chk_slices("one", 16'h0001, 8'h01, 8'h00);

    // 0x8000 after reset: A0 = 01 only on the sign slice
    do_reset();
    push(16'h8000, 0);
    chk_slices("msb", 16'h8000, 8'h01, 8'h00);

    // nine all-ones samples fill taps 0..8
    do_reset();
    for (int n = 0; n < 9; n++) push(16'hFFFF, 0);
    chk_slices("nine", 16'hFFFF, 8'hFF, 8'h01);

    // reset at slice 7 abandons the output and clears the line
    wait_ready();
    x_in = 16'h1234; x_valid = 1'b1;
    @(negedge clk);
    x_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_reset_sv", {31'd0, slice_valid}, 32'd1);
    #2 reset = 1'b1;
    #1 chk("mid_reset_out", {slice_valid, start_out, last_slice,
                             A7 | A6 | A5 | A4 | A3 | A2 | A1 | A0}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    push(16'h0001, 0);
    chk_slices("post_reset", 16'h0001, 8'h01, 8'h00);

    // x_valid held through SLICE/WAIT with changing data, da_done 5 cycles late
    do_reset();
    wait_ready();
    x_in = 16'h0003; x_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      capture(i);
      x_in = 16'(32'hA500 + i);
      @(negedge clk);
    end
    repeat (5) begin
      chk("hold_ready_low", {31'd0, x_ready}, 32'd0);
      x_in = x_in + 16'h0101;
      @(negedge clk);
    end
    da_done = 1'b1;
    chk("done_cycle_ready", {31'd0, x_ready}, 32'd0);
    @(negedge clk);
    da_done = 1'b0;
    x_valid = 1'b0;
    chk("ready_after_done", {31'd0, x_ready}, 32'd1);
    chk_slices("hold", 16'h0003, 8'h01, 8'h00);
    // only 0x0003 entered the line: tap1 = 0003, tap0 = new 0000
    push(16'h0000, 0);
    chk("hold_no_extra", {24'd0, cap_a[0][0]}, 32'h02);

`ifdef DA_SLICER_FLUSH_EN
    // flush wins over a simultaneous sample and clears the line
    wait_ready();
    flush = 1'b1; x_valid = 1'b1; x_in = 16'hFFFF;
    #1 chk("flush_ready", {31'd0, x_ready}, 32'd0);
    @(negedge clk);
    flush = 1'b0; x_valid = 1'b0;
    push(16'h0001, 0);
    chk_slices("flush", 16'h0001, 8'h01, 8'h00);
`endif

    // assorted samples and done delays, checked by the cycle model
    for (int n = 0; n < 6; n++) push(rv[n], rd[n]);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
